pattern_detect_prog: RTL and testbench
======================================

# pattern_detect_prog

Programmable serial pattern detector: the parametrised successor to the fixed-sequence `pattern_detect`. It sits on a 1-bit serial stream qualified by `valid_i` and accepts a runtime-loaded pattern of 1..PAT_W bits. Overlap or non-overlap matching is selected at load time. Each match produces a one-cycle `pattern` pulse and increments a saturating match counter.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: match counter width (≥2).

- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `d_i`  in  1  serial data bit.
- `valid_i`  in  1  `d_i` qualifier; a bit is accepted on an edge with `valid_i=1`.
- `load_i`  in  1  captures `pat_i`, `len_i` and `ovl_i`.
- `pat_i`  in  PAT_W  pattern; `pat_i[len-1]` is the first bit received, `pat_i[0]` the last.
- `len_i`  in  LEN_W  pattern length, where LEN_W = $clog2(PAT_W+1); legal range 1..PAT_W.
- `ovl_i`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `clear_i`  in  1  clears the match counter.
- `pattern`  out  1  match pulse, one cycle per match.
- `match_cnt_o`  out  CNT_W  saturating count of matches.
- `cnt_sat_o`  out  1  high while `match_cnt_o` equals all-ones.
- `armed_o`  out  1  high in state RUN.

## Operation
- FSM states:
  - IDLE: no pattern loaded; accepted bits are ignored.
  - RUN: searching.
- Transitions:
  - IDLE→RUN on `load_i` with legal `len_i`.
  - RUN→RUN on `load_i` with legal `len_i`: reload.
  - `load_i` with `len_i`=0 or `len_i`>PAT_W is ignored; state and registers are unchanged.
  - Any state→IDLE only on `rst`.
- A legal load stores pattern, length and overlap mode, and clears the history register `hist` (PAT_W bits) and the fill count `fill` (0..PAT_W).
- Accepted bit in RUN:
  - shift: `hist <= {hist[PAT_W-2:0], d_i}`;
  - `fill <= min(fill+1, PAT_W)`.
- Match condition, evaluated on the post-shift values: `fill_next ≥ len` and `hist_next[len-1:0] == pat[len-1:0]`.
- On a match:
  - `pattern` is asserted.
  - The counter increments unless it is saturated.
  - Overlap mode: `hist` and `fill` are kept.
  - Non-overlap mode: `fill` is cleared to 0, so the next match needs `len` fresh bits.
- `valid_i=0`: no state change; `pattern` is 0 on that edge.
- Simultaneous events:
  - `load_i` and an accepted bit: load wins, and the bit is discarded.
  - `clear_i` and a match: the counter is 0 afterwards; `pattern` still pulses.
  - `rst` overrides everything.
- Reset mid-operation: the pattern is lost and the block is in IDLE; it must be reloaded before detection resumes.

## Timing
- Reset values:
  - state = IDLE;
  - `pattern` = 0, `match_cnt_o` = 0, `cnt_sat_o` = 0, `armed_o` = 0;
  - `hist` = 0, `fill` = 0, stored pattern/length/mode = 0.
- `pattern` is registered. For a bit accepted at edge N that completes a match, `pattern` is high from edge N to edge N+1 exactly.
- Back-to-back pulses are legal in overlap mode; example: pattern `11`, stream `111` gives pulses on the 2nd and 3rd bits.
- `match_cnt_o` and `cnt_sat_o` update on the same edge as `pattern`.
- `armed_o` rises on the edge that performs the load.
- The first bit that can count toward a match is the first accepted bit after the load edge.
- There is no backpressure; every edge with `valid_i=1` is consumed.

## Structure
- Package `pattern_detect_pkg`:
  - state encoding constants `ST_IDLE`, `ST_RUN`;
  - LEN_W helper function (`$clog2(PAT_W+1)`).
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst`, `inc_i`, `clr_i`, `cnt_o`, `sat_o`), instantiated for the match counter. Clear has priority over increment.
- The length-masked compare is combinational inside the top module: build the mask from `len` and compare `(hist_next ^ pat) & mask == 0`.

## Test plan
- Reset/IDLE: `rst` for 2 cycles, then stream 1,0,1,1 without load → `pattern` never asserts, `armed_o=0`, count 0.
- Overlap: load `pat_i=8'b0000_1011`, `len_i=4`, `ovl_i=1`; stream 1,0,1,1,0,1,1 → `pattern` pulses after bits 4 and 7; `match_cnt_o=2`.
- Non-overlap: same pattern and stream with `ovl_i=0` → a single pulse after bit 4; `match_cnt_o=1`.
- Valid gaps: the overlap stream with `valid_i=0` inserted between every bit → the same 2 pulses, each exactly one cycle, on the edges accepting bits 4 and 7.
- Saturation: `CNT_W=4`, pattern `11`, `len_i=2`, overlap on, 20 consecutive 1s → `match_cnt_o=15`, `cnt_sat_o=1`, `pattern` still pulsing; assert `clear_i` → count 0 and `cnt_sat_o=0` on the next edge.
- Corner events, each checked separately:
  - `load_i` coincident with a valid bit → the bit is not counted toward the next match.
  - `len_i=0` load in IDLE → stays IDLE.
  - `rst` mid-stream → IDLE, all outputs 0.
  - `clear_i` on a match edge → count 0.

Source files
------------

// File: rtl/pattern_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   state_e : FSM encoding (ST_IDLE = no pattern loaded, ST_RUN = searching)
//   len_w() : width needed to hold a pattern length of 0..pat_w
package pattern_detect_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pattern_detect_if.sv
// Stream, programming and status signals of the pattern detector.
//   master : drives d_i/valid_i/load_i/pat_i/len_i/ovl_i/clear_i, observes status
//   slave  : the detector; drives pattern/match_cnt_o/cnt_sat_o/armed_o
interface pattern_detect_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) ();
    import pattern_detect_pkg::*;

    localparam int unsigned LEN_W = len_w(PAT_W);

    logic             d_i;
    logic             valid_i;
    logic             load_i;
    logic [PAT_W-1:0] pat_i;
    logic [LEN_W-1:0] len_i;
    logic             ovl_i;
    logic             clear_i;
    logic             pattern;
    logic [CNT_W-1:0] match_cnt_o;
    logic             cnt_sat_o;
    logic             armed_o;

    modport master (
        output d_i, valid_i, load_i, pat_i, len_i, ovl_i, clear_i,
        input  pattern, match_cnt_o, cnt_sat_o, armed_o
    );

    modport slave (
        input  d_i, valid_i, load_i, pat_i, len_i, ovl_i, clear_i,
        output pattern, match_cnt_o, cnt_sat_o, armed_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : count up by one unless already all-ones
//   clr_i    : force to zero; wins over inc_i
//   cnt_o    : current count
//   sat_o    : high while cnt_o is all-ones
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && !w_sat) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;
    assign sat_o = w_sat;

endmodule

// File: rtl/pattern_detect_prog.sv
// Programmable serial pattern detector.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pattern_detect_if slave; serial bit + valid, pattern load
//              (pattern/length/overlap), counter clear, and the match pulse,
//              saturating match count, saturation flag and armed status.
// The most recent bits sit in r_hist with the newest at bit 0, so the stored
// pattern lines up directly: pat[len-1] is the oldest bit of the window.
module pattern_detect_prog
    import pattern_detect_pkg::*;
#(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    pattern_detect_if.slave  bus
);

    localparam int unsigned LEN_W = len_w(PAT_W);

    state_e           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_fill;
    logic             r_ovl;
    logic             r_pattern;

    logic             w_len_legal;
    logic             w_load;
    logic             w_accept;
    logic             w_match;
    logic [PAT_W-1:0] w_hist_next;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_next;

    assign w_len_legal = (bus.len_i != '0) && (bus.len_i <= LEN_W'(PAT_W));
    assign w_load      = bus.load_i && w_len_legal;
    // A legal load takes the edge; a coincident bit is dropped.
    assign w_accept    = bus.valid_i && (r_state == ST_RUN) && !w_load;

    assign w_hist_next = {r_hist[PAT_W-2:0], bus.d_i};
    assign w_fill_next = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_match = w_accept && (w_fill_next >= r_len) &&
                     (((w_hist_next ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_hist    <= '0;
            r_len     <= '0;
            r_fill    <= '0;
            r_ovl     <= 1'b0;
            r_pattern <= 1'b0;
        end else begin
            r_pattern <= w_match;
            if (w_load) begin
                r_state <= ST_RUN;
                r_pat   <= bus.pat_i;
                r_len   <= bus.len_i;
                r_ovl   <= bus.ovl_i;
                r_hist  <= '0;
                r_fill  <= '0;
            end else if (w_accept) begin
                r_hist <= w_hist_next;
                // Non-overlap restarts the fill so the next match needs len fresh bits.
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_next;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_match),
        .clr_i (bus.clear_i),
        .cnt_o (bus.match_cnt_o),
        .sat_o (bus.cnt_sat_o)
    );

    assign bus.pattern = r_pattern;
    assign bus.armed_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_pattern_detect_prog.sv
// Scoreboard bench for pattern_detect_prog. The driver pushes the expected
// outputs of every clock edge from a bit-list reference model; a monitor pops
// and compares one entry on each falling edge.
module tb_pattern_detect_prog;

    localparam int unsigned PAT_W   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LEN_W   = pattern_detect_pkg::len_w(PAT_W);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             pat;
        logic [CNT_W-1:0] cnt;
        logic             sat;
        logic             armed;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_detect_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    pattern_detect_prog #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the accepted bits since the last load / non-overlap match.
    bit               m_run;
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_bits[$];
    int               m_cnt;

    task automatic model_step(input bit r, input bit d, input bit v, input bit ld,
                              input logic [PAT_W-1:0] p, input int l, input bit o,
                              input bit c);
        exp_t e;
        bit   hit;
        hit = 1'b0;
        if (r) begin
            m_run = 1'b0;
            m_pat = '0;
            m_len = 0;
            m_ovl = 1'b0;
            m_bits.delete();
            m_cnt = 0;
        end else begin
            if (ld && l >= 1 && l <= PAT_W) begin
                m_run = 1'b1;
                m_pat = p;
                m_len = l;
                m_ovl = o;
                m_bits.delete();
            end else if (v && m_run) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    hit = 1'b1;
                    for (int j = 0; j < m_len; j++) begin
                        if (m_bits[m_bits.size() - m_len + j] != m_pat[m_len - 1 - j]) hit = 1'b0;
                    end
                end
                if (hit && !m_ovl) m_bits.delete();
            end
            if (c) m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt++;
        end
        e.pat   = hit;
        e.cnt   = CNT_W'(m_cnt);
        e.sat   = (m_cnt == CNT_MAX);
        e.armed = m_run;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit d, input bit v, input bit ld,
                        input logic [PAT_W-1:0] p, input int l, input bit o, input bit c);
        rst         = r;
        bus.d_i     = d;
        bus.valid_i = v;
        bus.load_i  = ld;
        bus.pat_i   = p;
        bus.len_i   = LEN_W'(l);
        bus.ovl_i   = o;
        bus.clear_i = c;
        @(posedge clk);
        model_step(r, d, v, ld, p, l, o, c);
        #1;
    endtask

    task automatic bit_in(input bit d);
        step(1'b0, d, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int l, input bit o);
        step(1'b0, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    // Directed spot checks against fixed expected values, taken 1 time unit after the edge.
    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {bus.pattern, bus.match_cnt_o, bus.cnt_sat_o, bus.armed_o};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb @%0t: got pat=%b cnt=%0d sat=%b armed=%b expected pat=%b cnt=%0d sat=%b armed=%b",
                             $time, got.pat, got.cnt, got.sat, got.armed,
                             e.pat, e.cnt, e.sat, e.armed);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s7[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset and IDLE: bits without a load are ignored.
        do_rst();
        do_rst();
        chk("rst_armed", int'(bus.armed_o), 0);
        chk("rst_cnt", int'(bus.match_cnt_o), 0);
        chk("rst_pattern", int'(bus.pattern), 0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        chk("idle_cnt", int'(bus.match_cnt_o), 0);
        chk("idle_armed", int'(bus.armed_o), 0);

        // Overlap: 1011 in 1011011 matches twice.
        load(8'b0000_1011, 4, 1'b1);
        chk("load_armed", int'(bus.armed_o), 1);
        foreach (s7[i]) bit_in(s7[i]);
        chk("ovl_cnt", int'(bus.match_cnt_o), 2);

        // Non-overlap: only one match.
        do_rst();
        load(8'b0000_1011, 4, 1'b0);
        foreach (s7[i]) bit_in(s7[i]);
        chk("novl_cnt", int'(bus.match_cnt_o), 1);

        // Valid gaps between every bit.
        do_rst();
        load(8'b0000_1011, 4, 1'b1);
        foreach (s7[i]) begin
            bit_in(s7[i]);
            gap();
            chk("gap_no_pulse", int'(bus.pattern), 0);
        end
        chk("gap_cnt", int'(bus.match_cnt_o), 2);

        // Saturation, then clear.
        do_rst();
        load(8'b0000_0011, 2, 1'b1);
        repeat (20) bit_in(1'b1);
        chk("sat_cnt", int'(bus.match_cnt_o), CNT_MAX);
        chk("sat_flag", int'(bus.cnt_sat_o), 1);
        chk("sat_pulse", int'(bus.pattern), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
        chk("clr_cnt", int'(bus.match_cnt_o), 0);
        chk("clr_sat", int'(bus.cnt_sat_o), 0);

        // Load coincident with a valid bit: that bit is discarded.
        do_rst();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0011, 2, 1'b1, 1'b0);
        bit_in(1'b1);
        chk("ldbit_no_match", int'(bus.pattern), 0);
        bit_in(1'b1);
        chk("ldbit_match", int'(bus.pattern), 1);

        // Illegal lengths in IDLE are ignored.
        do_rst();
        load(8'hFF, 0, 1'b1);
        chk("len0_idle", int'(bus.armed_o), 0);
        load(8'hFF, PAT_W + 1, 1'b1);
        chk("len9_idle", int'(bus.armed_o), 0);

        // Reset mid-stream loses the pattern.
        load(8'b0000_1011, 4, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        do_rst();
        chk("midrst_armed", int'(bus.armed_o), 0);
        chk("midrst_cnt", int'(bus.match_cnt_o), 0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        chk("midrst_nomatch", int'(bus.match_cnt_o), 0);

        // Clear on a match edge: pulse still, count 0.
        load(8'b0000_0011, 2, 1'b1);
        bit_in(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
        chk("clrmatch_pulse", int'(bus.pattern), 1);
        chk("clrmatch_cnt", int'(bus.match_cnt_o), 0);

        // Randomised traffic, short patterns favoured so matches are frequent.
        for (int n = 0; n < 2000; n++) begin
            bit               r, d, v, ld, o, c;
            logic [PAT_W-1:0] p;
            int               l;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 29) == 0);
            p  = PAT_W'($urandom);
            l  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(1, 4));
            o  = $urandom_range(0, 1) != 0;
            v  = $urandom_range(0, 3) != 0;
            d  = $urandom_range(0, 1) != 0;
            c  = ($urandom_range(0, 49) == 0);
            step(r, d, v, ld, p, l, o, c);
        end

        gap();
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
